// File: rtl/snitch_icache_pkg.sv
// Shared types and helpers for the Snitch instruction cache hierarchy.
package snitch_icache_pkg;

  typedef struct packed {
    int unsigned nr_ports;
    int unsigned fetch_aw;
    int unsigned line_width;
    int unsigned id_width;
    int unsigned pf_age_max;
  } config_t;

  // The refill ID carries two one-hot bits per L0 port (demand and prefetch),
  // so the ID width is always derived from the port count.
  function automatic config_t make_l0_cfg(int unsigned nr_ports, int unsigned fetch_aw,
                                          int unsigned line_width, int unsigned pf_age_max);
    config_t cfg;
    cfg.nr_ports   = nr_ports;
    cfg.fetch_aw   = fetch_aw;
    cfg.line_width = line_width;
    cfg.id_width   = 2 * nr_ports;
    cfg.pf_age_max = pf_age_max;
    return cfg;
  endfunction

  function automatic int unsigned l0_demand_bit(int unsigned p);
    return 2 * p;
  endfunction

  function automatic int unsigned l0_prefetch_bit(int unsigned p);
    return 2 * p + 1;
  endfunction

endpackage

// File: rtl/snitch_icache_rr_pick.sv
// Round-robin picker: first set request at or after the pointer, wrapping around.
module snitch_icache_rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] cand;

  // Scan from the pointer upward; the first hit wins and later hits are ignored.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IW'((32'(ptr_i) + i) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/snitch_icache_l0_refill_arb.sv
// Shares the L1 refill channel among the private L0 caches: arbitrates requests
// (demand over prefetch, aged prefetches first) and multicasts responses.
module snitch_icache_l0_refill_arb
  import snitch_icache_pkg::*;
#(
  parameter int unsigned NR_PORTS   = 4,
  parameter int unsigned FETCH_AW   = 48,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned PF_AGE_MAX = 8,
  localparam config_t     Cfg       = make_l0_cfg(NR_PORTS, FETCH_AW, LINE_WIDTH, PF_AGE_MAX),
  localparam int unsigned ID_WIDTH  = Cfg.id_width
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NR_PORTS*FETCH_AW-1:0]   in_req_addr_i,
  input  logic [NR_PORTS*ID_WIDTH-1:0]   in_req_id_i,
  input  logic [NR_PORTS-1:0]            in_req_valid_i,
  output logic [NR_PORTS-1:0]            in_req_ready_o,
  output logic [FETCH_AW-1:0]            out_req_addr_o,
  output logic [ID_WIDTH-1:0]            out_req_id_o,
  output logic                           out_req_valid_o,
  input  logic                           out_req_ready_i,
  input  logic [LINE_WIDTH-1:0]          out_rsp_data_i,
  input  logic                           out_rsp_error_i,
  input  logic [ID_WIDTH-1:0]            out_rsp_id_i,
  input  logic                           out_rsp_valid_i,
  output logic                           out_rsp_ready_o,
  output logic [NR_PORTS*LINE_WIDTH-1:0] in_rsp_data_o,
  output logic [NR_PORTS-1:0]            in_rsp_error_o,
  output logic [NR_PORTS*ID_WIDTH-1:0]   in_rsp_id_o,
  output logic [NR_PORTS-1:0]            in_rsp_valid_o,
  input  logic [NR_PORTS-1:0]            in_rsp_ready_i
);

  localparam int unsigned IdxW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam int unsigned AgeW = (PF_AGE_MAX > 0) ? $clog2(PF_AGE_MAX + 1) : 1;

  logic [NR_PORTS-1:0] is_pf, dem_req, pf_req, aged_req, pf_pick_req, targeted;
  logic [NR_PORTS-1:0] dem_gnt, pf_gnt, win_gnt;
  logic [IdxW-1:0]     dem_idx, pf_idx, win_idx, next_ptr;
  logic                dem_valid, pf_valid, win_valid, win_is_pf, grant;

  logic [IdxW-1:0]     rr_dem_q, rr_dem_d, rr_pf_q, rr_pf_d;
  logic [NR_PORTS-1:0][AgeW-1:0] age_q, age_d;
  logic                out_valid_q, out_valid_d;
  logic [FETCH_AW-1:0] out_addr_q, out_addr_d;
  logic [ID_WIDTH-1:0] out_id_q, out_id_d;

  // Per-port request class, response targeting and prefetch age tracking.
  for (genvar p = 0; p < NR_PORTS; p++) begin : gen_port
    assign is_pf[p]    = in_req_id_i[p*ID_WIDTH + l0_prefetch_bit(p)];
    assign targeted[p] = out_rsp_id_i[l0_demand_bit(p)] | out_rsp_id_i[l0_prefetch_bit(p)];
    assign aged_req[p] = (PF_AGE_MAX != 0) && pf_req[p] && (age_q[p] == AgeW'(PF_AGE_MAX));
    assign age_d[p]    = (!pf_req[p] || (grant && win_gnt[p])) ? '0 :
                         (age_q[p] == AgeW'(PF_AGE_MAX))       ? age_q[p] :
                                                                 age_q[p] + AgeW'(1);
  end

  assign dem_req     = in_req_valid_i & ~is_pf;
  assign pf_req      = in_req_valid_i & is_pf;
  assign pf_pick_req = (|aged_req) ? aged_req : pf_req;

  snitch_icache_rr_pick #(.N(NR_PORTS)) i_pick_dem (
    .req_i   (dem_req),
    .ptr_i   (rr_dem_q),
    .gnt_o   (dem_gnt),
    .idx_o   (dem_idx),
    .valid_o (dem_valid)
  );

  // Aged prefetches share the prefetch pointer with ordinary prefetches.
  snitch_icache_rr_pick #(.N(NR_PORTS)) i_pick_pf (
    .req_i   (pf_pick_req),
    .ptr_i   (rr_pf_q),
    .gnt_o   (pf_gnt),
    .idx_o   (pf_idx),
    .valid_o (pf_valid)
  );

  // Pick the class (aged, then demand, then prefetch) and grant if the output stage can take it.
  always_comb begin
    win_is_pf      = (|aged_req) || !(|dem_req);
    win_valid      = win_is_pf ? pf_valid : dem_valid;
    win_idx        = win_is_pf ? pf_idx   : dem_idx;
    win_gnt        = win_is_pf ? pf_gnt   : dem_gnt;
    next_ptr       = IdxW'((32'(win_idx) + 1) % NR_PORTS);
    grant          = win_valid && (!out_valid_q || out_req_ready_i);
    in_req_ready_o = grant ? win_gnt : '0;
  end

  // Output register and pointer update; a grant in a drain cycle overwrites the stage.
  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_id_d    = out_id_q;
    rr_dem_d    = rr_dem_q;
    rr_pf_d     = rr_pf_q;
    if (grant) begin
      out_valid_d = 1'b1;
      out_addr_d  = in_req_addr_i[win_idx*FETCH_AW +: FETCH_AW];
      out_id_d    = in_req_id_i[win_idx*ID_WIDTH +: ID_WIDTH];
      if (win_is_pf) begin
        rr_pf_d = next_ptr;
      end else begin
        rr_dem_d = next_ptr;
      end
    end else if (out_req_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset drops any buffered request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_id_q    <= '0;
      rr_dem_q    <= '0;
      rr_pf_q     <= '0;
      age_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_id_q    <= out_id_d;
      rr_dem_q    <= rr_dem_d;
      rr_pf_q     <= rr_pf_d;
      age_q       <= age_d;
    end
  end

  assign out_req_valid_o = out_valid_q;
  assign out_req_addr_o  = out_addr_q;
  assign out_req_id_o    = out_id_q;

  // Responses are broadcast; only valid is filtered, and a stray ID 0 is simply dropped.
  assign in_rsp_data_o   = {NR_PORTS{out_rsp_data_i}};
  assign in_rsp_error_o  = {NR_PORTS{out_rsp_error_i}};
  assign in_rsp_id_o     = {NR_PORTS{out_rsp_id_i}};
  assign in_rsp_valid_o  = {NR_PORTS{out_rsp_valid_i}} & targeted;
  assign out_rsp_ready_o = &(in_rsp_ready_i | ~targeted);

  a_ready_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(in_req_ready_o));

  a_stall_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_req_valid_o && !out_req_ready_i) |=>
      (out_req_valid_o && $stable(out_req_addr_o) && $stable(out_req_id_o)));

  for (genvar p = 0; p < NR_PORTS; p++) begin : gen_id_chk
    a_id_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
      in_req_valid_i[p] |-> $onehot(in_req_id_i[p*ID_WIDTH +: ID_WIDTH]));
  end

endmodule

// File: tb/tb_snitch_icache_l0_refill_arb.sv
// Self-checking bench for the L0 refill arbiter (4 ports, prefetch age limit 3).
module tb_snitch_icache_l0_refill_arb;

  localparam int unsigned NP  = 4;
  localparam int unsigned AW  = 48;
  localparam int unsigned LW  = 128;
  localparam int unsigned IDW = 8;

  typedef struct packed {
    logic [AW-1:0]  addr;
    logic [IDW-1:0] id;
  } req_t;

  logic               clk_i;
  logic               rst_ni;
  logic [NP*AW-1:0]   in_req_addr_i;
  logic [NP*IDW-1:0]  in_req_id_i;
  logic [NP-1:0]      in_req_valid_i;
  logic [NP-1:0]      in_req_ready_o;
  logic [AW-1:0]      out_req_addr_o;
  logic [IDW-1:0]     out_req_id_o;
  logic               out_req_valid_o;
  logic               out_req_ready_i;
  logic [LW-1:0]      out_rsp_data_i;
  logic               out_rsp_error_i;
  logic [IDW-1:0]     out_rsp_id_i;
  logic               out_rsp_valid_i;
  logic               out_rsp_ready_o;
  logic [NP*LW-1:0]   in_rsp_data_o;
  logic [NP-1:0]      in_rsp_error_o;
  logic [NP*IDW-1:0]  in_rsp_id_o;
  logic [NP-1:0]      in_rsp_valid_o;
  logic [NP-1:0]      in_rsp_ready_i;

  logic [AW-1:0]  req_addr [NP];
  logic [IDW-1:0] req_id   [NP];
  req_t           sb_q [$];
  int             checks;
  int             errors;

  snitch_icache_l0_refill_arb #(
    .NR_PORTS   (NP),
    .FETCH_AW   (AW),
    .LINE_WIDTH (LW),
    .PF_AGE_MAX (3)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .in_req_addr_i   (in_req_addr_i),
    .in_req_id_i     (in_req_id_i),
    .in_req_valid_i  (in_req_valid_i),
    .in_req_ready_o  (in_req_ready_o),
    .out_req_addr_o  (out_req_addr_o),
    .out_req_id_o    (out_req_id_o),
    .out_req_valid_o (out_req_valid_o),
    .out_req_ready_i (out_req_ready_i),
    .out_rsp_data_i  (out_rsp_data_i),
    .out_rsp_error_i (out_rsp_error_i),
    .out_rsp_id_i    (out_rsp_id_i),
    .out_rsp_valid_i (out_rsp_valid_i),
    .out_rsp_ready_o (out_rsp_ready_o),
    .in_rsp_data_o   (in_rsp_data_o),
    .in_rsp_error_o  (in_rsp_error_o),
    .in_rsp_id_o     (in_rsp_id_o),
    .in_rsp_valid_o  (in_rsp_valid_o),
    .in_rsp_ready_i  (in_rsp_ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Flatten the per-port request arrays onto the DUT buses.
  always_comb begin
    in_req_addr_i = '0;
    in_req_id_i   = '0;
    for (int p = 0; p < NP; p++) begin
      in_req_addr_i[p*AW +: AW]  = req_addr[p];
      in_req_id_i[p*IDW +: IDW] = req_id[p];
    end
  end

  // Scoreboard consumer: every L1 handshake must match the oldest expected request.
  task automatic monitor_out();
    req_t exp;
    forever begin
      @(negedge clk_i);
      if (rst_ni && out_req_valid_o && out_req_ready_i) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL out_unexpected: got addr=%h id=%h, required none", out_req_addr_o, out_req_id_o);
        end else begin
          exp = sb_q.pop_front();
          if (out_req_addr_o !== exp.addr || out_req_id_o !== exp.id) begin
            errors++;
            $display("[TB] FAIL out_req: got addr=%h id=%h, required addr=%h id=%h",
                     out_req_addr_o, out_req_id_o, exp.addr, exp.id);
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_ni          = 1'b0;
    in_req_valid_i  = '0;
    out_req_ready_i = 1'b0;
    out_rsp_data_i  = '0;
    out_rsp_error_i = 1'b0;
    out_rsp_id_i    = '0;
    out_rsp_valid_i = 1'b0;
    in_rsp_ready_i  = '0;
    for (int p = 0; p < NP; p++) begin
      req_addr[p] = '0;
      req_id[p]   = '0;
    end
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    sb_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_req_valid_o !== 1'b0 || out_req_addr_o !== '0 || out_req_id_o !== '0) begin
      errors++;
      $display("[TB] FAIL reset_out: got valid=%b addr=%h id=%h, required 0/0/0",
               out_req_valid_o, out_req_addr_o, out_req_id_o);
    end
    checks++;
    if (in_req_ready_o !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b, required 0000", in_req_ready_o);
    end
    checks++;
    if (out_rsp_ready_o !== 1'b1 || in_rsp_valid_o !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_rsp: got ready=%b valid=%b, required 1/0000", out_rsp_ready_o, in_rsp_valid_o);
    end
  endtask

  task automatic test_round_robin();
    int e;
    do_reset();
    out_req_ready_i = 1'b1;
    for (int p = 0; p < NP; p++) begin
      req_addr[p] = 48'h1_0000 + 48'(p * 256);
      req_id[p]   = 8'(1 << (2 * p));
    end
    in_req_valid_i = 4'hF;
    for (int k = 0; k < 5; k++) begin
      e = k % 4;
      @(negedge clk_i);
      checks++;
      if (in_req_ready_o !== 4'(1 << e)) begin
        errors++;
        $display("[TB] FAIL rr_grant[%0d]: got %b, required %b", k, in_req_ready_o, 4'(1 << e));
      end
      checks++;
      if (out_req_valid_o !== (k > 0)) begin
        errors++;
        $display("[TB] FAIL rr_out_valid[%0d]: got %b, required %b", k, out_req_valid_o, (k > 0));
      end
      sb_q.push_back({req_addr[e], req_id[e]});
      @(posedge clk_i);
      #1;
      req_addr[e] = req_addr[e] + 48'h10;
    end
    in_req_valid_i = '0;
    for (int c = 0; c < 10 && sb_q.size() != 0; c++) @(negedge clk_i);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL rr_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_demand_priority();
    do_reset();
    out_req_ready_i = 1'b1;
    req_addr[1] = 48'h2_0000;
    req_id[1]   = 8'h08;
    req_addr[2] = 48'h3_0000;
    req_id[2]   = 8'h10;
    in_req_valid_i = 4'b0110;
    @(negedge clk_i);
    checks++;
    if (in_req_ready_o !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL prio_first: got %b, required 0100", in_req_ready_o);
    end
    sb_q.push_back({req_addr[2], req_id[2]});
    @(posedge clk_i);
    #1;
    in_req_valid_i = 4'b0010;
    @(negedge clk_i);
    checks++;
    if (in_req_ready_o !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL prio_second: got %b, required 0010", in_req_ready_o);
    end
    sb_q.push_back({req_addr[1], req_id[1]});
    @(posedge clk_i);
    #1;
    in_req_valid_i = '0;
    for (int c = 0; c < 10 && sb_q.size() != 0; c++) @(negedge clk_i);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL prio_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_prefetch_aging();
    int order [4];
    order = '{1, 2, 3, 0};
    do_reset();
    out_req_ready_i = 1'b1;
    req_addr[0] = 48'h4_0000;
    req_id[0]   = 8'h02;
    for (int p = 1; p < NP; p++) begin
      req_addr[p] = 48'h5_0000 + 48'(p * 256);
      req_id[p]   = 8'(1 << (2 * p));
    end
    in_req_valid_i = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      checks++;
      if (in_req_ready_o !== 4'(1 << order[k])) begin
        errors++;
        $display("[TB] FAIL age_grant[%0d]: got %b, required %b", k, in_req_ready_o, 4'(1 << order[k]));
      end
      sb_q.push_back({req_addr[order[k]], req_id[order[k]]});
      @(posedge clk_i);
      #1;
      req_addr[order[k]] = req_addr[order[k]] + 48'h10;
    end
    in_req_valid_i = '0;
    for (int c = 0; c < 10 && sb_q.size() != 0; c++) @(negedge clk_i);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL age_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_req_ready_i = 1'b0;
    req_addr[0] = 48'h1000;
    req_id[0]   = 8'h01;
    in_req_valid_i = 4'b0001;
    @(negedge clk_i);
    checks++;
    if (in_req_ready_o !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL bp_first: got %b, required 0001", in_req_ready_o);
    end
    sb_q.push_back({req_addr[0], req_id[0]});
    @(posedge clk_i);
    #1;
    req_addr[1] = 48'h2000;
    req_id[1]   = 8'h04;
    in_req_valid_i = 4'b0010;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk_i);
      checks++;
      if (in_req_ready_o !== 4'b0000 || out_req_valid_o !== 1'b1 ||
          out_req_addr_o !== 48'h1000 || out_req_id_o !== 8'h01) begin
        errors++;
        $display("[TB] FAIL bp_stall[%0d]: got ready=%b valid=%b addr=%h id=%h, required 0000/1/1000/01",
                 s, in_req_ready_o, out_req_valid_o, out_req_addr_o, out_req_id_o);
      end
    end
    @(posedge clk_i);
    #1;
    out_req_ready_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (in_req_ready_o !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL bp_release: got %b, required 0010", in_req_ready_o);
    end
    sb_q.push_back({req_addr[1], req_id[1]});
    @(posedge clk_i);
    #1;
    in_req_valid_i = '0;
    @(negedge clk_i);
    checks++;
    if (out_req_valid_o !== 1'b1 || out_req_addr_o !== 48'h2000) begin
      errors++;
      $display("[TB] FAIL bp_next: got valid=%b addr=%h, required 1/2000", out_req_valid_o, out_req_addr_o);
    end
    for (int c = 0; c < 10 && sb_q.size() != 0; c++) @(negedge clk_i);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL bp_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_multicast_response();
    logic [LW-1:0] data;
    data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
    out_rsp_data_i  = data;
    out_rsp_error_i = 1'b1;
    out_rsp_id_i    = 8'h09;
    out_rsp_valid_i = 1'b1;
    in_rsp_ready_i  = 4'b1101;
    #1;
    checks++;
    if (in_rsp_valid_o !== 4'b0011 || out_rsp_ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mc_partial: got valid=%b ready=%b, required 0011/0", in_rsp_valid_o, out_rsp_ready_o);
    end
    checks++;
    if (in_rsp_data_o[3*LW +: LW] !== data || in_rsp_id_o[1*IDW +: IDW] !== 8'h09 ||
        in_rsp_error_o !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL mc_broadcast: got data3=%h id1=%h err=%b, required %h/09/1111",
               in_rsp_data_o[3*LW +: LW], in_rsp_id_o[1*IDW +: IDW], in_rsp_error_o, data);
    end
    in_rsp_ready_i = 4'b1111;
    #1;
    checks++;
    if (out_rsp_ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mc_all_ready: got %b, required 1", out_rsp_ready_o);
    end
    out_rsp_id_i   = 8'h00;
    in_rsp_ready_i = 4'b0000;
    #1;
    checks++;
    if (in_rsp_valid_o !== 4'b0000 || out_rsp_ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mc_stray: got valid=%b ready=%b, required 0000/1", in_rsp_valid_o, out_rsp_ready_o);
    end
    out_rsp_id_i   = 8'h80;
    in_rsp_ready_i = 4'b0111;
    #1;
    checks++;
    if (in_rsp_valid_o !== 4'b1000 || out_rsp_ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mc_port3_pf: got valid=%b ready=%b, required 1000/0", in_rsp_valid_o, out_rsp_ready_o);
    end
    out_rsp_valid_i = 1'b0;
    #1;
    checks++;
    if (in_rsp_valid_o !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL mc_idle: got valid=%b, required 0000", in_rsp_valid_o);
    end
    out_rsp_id_i   = 8'h00;
    in_rsp_ready_i = 4'b0000;
  endtask

  task automatic test_reset_mid_operation();
    do_reset();
    out_req_ready_i = 1'b0;
    req_addr[0] = 48'h5000;
    req_id[0]   = 8'h01;
    in_req_valid_i = 4'b0001;
    @(negedge clk_i);
    checks++;
    if (in_req_ready_o !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL rmid_grant: got %b, required 0001", in_req_ready_o);
    end
    @(posedge clk_i);
    #1;
    in_req_valid_i = '0;
    checks++;
    if (out_req_valid_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rmid_full: got valid=%b, required 1", out_req_valid_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (out_req_valid_o !== 1'b0 || out_req_addr_o !== '0) begin
      errors++;
      $display("[TB] FAIL rmid_async: got valid=%b addr=%h, required 0/0", out_req_valid_o, out_req_addr_o);
    end
    sb_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    out_req_ready_i = 1'b1;
    for (int p = 0; p < NP; p++) begin
      req_addr[p] = 48'h6_0000 + 48'(p * 256);
      req_id[p]   = 8'(1 << (2 * p));
    end
    in_req_valid_i = 4'hF;
    @(negedge clk_i);
    checks++;
    if (in_req_ready_o !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL rmid_first: got %b, required 0001", in_req_ready_o);
    end
    sb_q.push_back({req_addr[0], req_id[0]});
    @(posedge clk_i);
    #1;
    in_req_valid_i = '0;
    for (int c = 0; c < 10 && sb_q.size() != 0; c++) @(negedge clk_i);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL rmid_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  // Run the scenarios in order with the scoreboard monitor alongside.
  initial begin
    checks = 0;
    errors = 0;
    rst_ni = 1'b0;
    fork
      monitor_out();
    join_none
    test_reset();
    test_round_robin();
    test_demand_priority();
    test_prefetch_aging();
    test_backpressure();
    test_multicast_response();
    test_reset_mid_operation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
